// File: rtl/ecc_secded_32bit_if.sv
// ============================================================================
// Module      : ecc_secded_32bit_if
// Description : Encode/decode bus bundle for the 32-bit SECDED block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ecc_secded_32bit_if;
    logic [31:0] enc_d;
    logic [38:0] enc_c;
    logic [38:0] dec_c;
    logic [31:0] dec_d;
    logic        no_err;
    logic        err_corrected;
    logic        err_fatal;

    modport master (
        output enc_d,
        output dec_c,
        input  enc_c,
        input  dec_d,
        input  no_err,
        input  err_corrected,
        input  err_fatal
    );

    modport slave (
        input  enc_d,
        input  dec_c,
        output enc_c,
        output dec_d,
        output no_err,
        output err_corrected,
        output err_fatal
    );
endinterface

`default_nettype wire

// File: rtl/ecc_secded_32bit.sv
// ============================================================================
// Module      : ecc_secded_32bit
// Description : (39,32) Hamming SECDED; combinational encoder, pipelined decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ecc_secded_32bit #(
    parameter int MIDDLE_REG = 1,
    parameter int OUTPUT_REG = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ecc_secded_32bit_if.slave bus
);

    localparam int C_CW_W   = 39;
    localparam int C_DATA_W = 32;
    localparam int C_CHK_W  = 6;
    localparam int C_LAST   = 38;

    // Positions 1,2,4,8,16,32 carry check bits; every other position 1..38 carries data.
    function automatic logic is_check_pos(input int pos);
        return (pos == 1) || (pos == 2) || (pos == 4) ||
               (pos == 8) || (pos == 16) || (pos == 32);
    endfunction

    function automatic logic [C_CW_W-1:0] scatter(input logic [C_DATA_W-1:0] d);
        logic [C_CW_W-1:0] c;
        int                j;
        c = '0;
        j = 0;
        for (int i = 1; i <= C_LAST; i++) begin
            if (!is_check_pos(i)) begin
                c[i] = d[j];
                j    = j + 1;
            end
        end
        return c;
    endfunction

    function automatic logic [C_DATA_W-1:0] gather(input logic [C_CW_W-1:0] c);
        logic [C_DATA_W-1:0] d;
        int                  j;
        d = '0;
        j = 0;
        for (int i = 1; i <= C_LAST; i++) begin
            if (!is_check_pos(i)) begin
                d[j] = c[i];
                j    = j + 1;
            end
        end
        return d;
    endfunction

    // ------------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------------
    logic [C_CW_W-1:0]  w_enc_raw;
    logic [C_CHK_W-1:0] w_enc_chk;
    logic [C_CW_W-1:0]  w_enc_full;

    always_comb begin
        w_enc_raw = scatter(bus.enc_d);
        w_enc_chk = '0;
        for (int k = 0; k < C_CHK_W; k++) begin
            for (int i = 1; i <= C_LAST; i++) begin
                if (i[k]) begin
                    w_enc_chk[k] = w_enc_chk[k] ^ w_enc_raw[i];
                end
            end
        end
        w_enc_full = w_enc_raw;
        for (int k = 0; k < C_CHK_W; k++) begin
            w_enc_full[1 << k] = w_enc_chk[k];
        end
        w_enc_full[0] = ^w_enc_full[C_LAST:1];
    end

    assign bus.enc_c = w_enc_full;

    // ------------------------------------------------------------------------
    // Decoder, syndrome stage
    // ------------------------------------------------------------------------
    logic [C_CHK_W-1:0] w_syn;
    logic               w_par;
    logic [C_CW_W-1:0]  w_fix_c;

    always_comb begin
        w_syn = '0;
        for (int i = 1; i <= C_LAST; i++) begin
            if (bus.dec_c[i]) begin
                w_syn = w_syn ^ C_CHK_W'(i);
            end
        end
        w_par   = ^bus.dec_c;
        w_fix_c = bus.dec_c;
        // Only odd-parity errors pointing inside 1..38 are repaired; s = 0 means c[0] itself.
        if (w_par) begin
            for (int i = 1; i <= C_LAST; i++) begin
                if (C_CHK_W'(i) == w_syn) begin
                    w_fix_c[i] = ~bus.dec_c[i];
                end
            end
        end
    end

    logic [C_CW_W-1:0]  w_mid_c;
    logic [C_CHK_W-1:0] w_mid_s;
    logic               w_mid_p;

    generate
        if (MIDDLE_REG != 0) begin : g_mid_reg
            logic [C_CW_W-1:0]  mid_c_q;
            logic [C_CHK_W-1:0] mid_s_q;
            logic               mid_p_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mid_c_q <= '0;
                    mid_s_q <= '0;
                    mid_p_q <= 1'b0;
                end else begin
                    mid_c_q <= w_fix_c;
                    mid_s_q <= w_syn;
                    mid_p_q <= w_par;
                end
            end

            assign w_mid_c = mid_c_q;
            assign w_mid_s = mid_s_q;
            assign w_mid_p = mid_p_q;
        end else begin : g_mid_comb
            assign w_mid_c = w_fix_c;
            assign w_mid_s = w_syn;
            assign w_mid_p = w_par;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Decoder, classification and data extraction
    // ------------------------------------------------------------------------
    logic [C_DATA_W-1:0] w_dec_d;
    logic                w_no_err;
    logic                w_err_corr;
    logic                w_err_fatal;
    logic                w_syn_zero;
    logic                w_syn_valid;

    always_comb begin
        w_dec_d     = gather(w_mid_c);
        w_syn_zero  = (w_mid_s == '0);
        w_syn_valid = (w_mid_s <= C_CHK_W'(C_LAST));
        w_no_err    = w_syn_zero && !w_mid_p;
        w_err_corr  = w_mid_p && w_syn_valid;
        w_err_fatal = !w_no_err && !w_err_corr;
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [C_DATA_W-1:0] dec_d_q;
            logic                no_err_q;
            logic                err_corr_q;
            logic                err_fatal_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dec_d_q     <= '0;
                    no_err_q    <= 1'b0;
                    err_corr_q  <= 1'b0;
                    err_fatal_q <= 1'b0;
                end else begin
                    dec_d_q     <= w_dec_d;
                    no_err_q    <= w_no_err;
                    err_corr_q  <= w_err_corr;
                    err_fatal_q <= w_err_fatal;
                end
            end

            assign bus.dec_d         = dec_d_q;
            assign bus.no_err        = no_err_q;
            assign bus.err_corrected = err_corr_q;
            assign bus.err_fatal     = err_fatal_q;
        end else begin : g_out_comb
            assign bus.dec_d         = w_dec_d;
            assign bus.no_err        = w_no_err;
            assign bus.err_corrected = w_err_corr;
            assign bus.err_fatal     = w_err_fatal;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ecc_secded_32bit.sv
// ============================================================================
// Module      : tb_ecc_secded_32bit
// Description : Directed checks of encoder, pipelined and combinational decoders.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ecc_secded_32bit;

    localparam logic [38:0] C_CW_BEEF = 39'h6F_AB6E_DCEF;
    localparam logic [31:0] C_BEEF    = 32'hDEADBEEF;
    localparam int          C_SOAK    = 400;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    ecc_secded_32bit_if u_bus ();
    ecc_secded_32bit_if u_bus_c ();

    ecc_secded_32bit #(.MIDDLE_REG(1), .OUTPUT_REG(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus.slave)
    );

    ecc_secded_32bit #(.MIDDLE_REG(0), .OUTPUT_REG(0)) u_dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (u_bus_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] pipe_out();
        return {u_bus.dec_d, u_bus.no_err, u_bus.err_corrected, u_bus.err_fatal};
    endfunction

    function automatic logic [34:0] comb_out();
        return {u_bus_c.dec_d, u_bus_c.no_err, u_bus_c.err_corrected, u_bus_c.err_fatal};
    endfunction

    task automatic drive_enc(input logic [31:0] d);
        u_bus.enc_d   = d;
        u_bus_c.enc_d = d;
    endtask

    task automatic drive_dec(input logic [38:0] c);
        u_bus.dec_c   = c;
        u_bus_c.dec_c = c;
    endtask

    // Present one codeword, check the combinational decoder at once and the pipelined one 2 edges later.
    task automatic dec_case(input string tag, input logic [38:0] c,
                            input logic [31:0] exp_d, input logic [2:0] exp_f);
        @(negedge clk);
        drive_dec(c);
        #1;
        check_eq({tag, "_comb"}, 64'(comb_out()), 64'({exp_d, exp_f}));
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq({tag, "_pipe"}, 64'(pipe_out()), 64'({exp_d, exp_f}));
    endtask

    task automatic soak_check(input string tag, input logic [34:0] obs,
                              input logic [31:0] exp_d, input int nf);
        case (nf)
            0:       check_eq(tag, 64'(obs), 64'({exp_d, 3'b100}));
            1:       check_eq(tag, 64'(obs), 64'({exp_d, 3'b010}));
            2:       check_eq(tag, 64'(obs[2:0]), 64'(3'b001));
            default: check_eq(tag, 64'($countones(obs[2:0])), 64'(1));
        endcase
    endtask

    logic [31:0] s_d  [0:C_SOAK-1];
    int          s_nf [0:C_SOAK-1];

    initial begin
        logic [38:0] cw;
        logic [38:0] mask;
        int          pos;
        int          k;

        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        drive_enc(32'h0);
        drive_dec(39'h0);

        #12;
        check_eq("reset_pipe", 64'(pipe_out()), 64'(0));
        check_eq("enc_zero", 64'(u_bus.enc_c), 64'(0));
        drive_enc(32'h00000001);
        #1;
        check_eq("enc_one", 64'(u_bus.enc_c), 64'(39'h00_0000_000F));
        drive_enc(32'h80000000);
        #1;
        check_eq("enc_msb", 64'(u_bus.enc_c), 64'(39'h41_0000_0014));
        drive_enc(C_BEEF);
        #1;
        check_eq("enc_beef", 64'(u_bus.enc_c), 64'(C_CW_BEEF));
        check_eq("enc_beef_parity", 64'(^u_bus.enc_c), 64'(0));

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("first_edge", 64'(pipe_out()), 64'({32'h0, 3'b100}));

        dec_case("clean_beef", C_CW_BEEF, C_BEEF, 3'b100);
        for (int b = 0; b < 39; b++) begin
            dec_case($sformatf("single_%0d", b), C_CW_BEEF ^ (39'd1 << b), C_BEEF, 3'b010);
        end
        dec_case("double_5_17", C_CW_BEEF ^ (39'd1 << 5) ^ (39'd1 << 17), 32'hDEADB6ED, 3'b001);
        dec_case("double_0_1", C_CW_BEEF ^ 39'd3, C_BEEF, 3'b001);
        // Syndrome 39 with odd parity: out-of-range position, left uncorrected.
        dec_case("invalid_syn", C_CW_BEEF ^ (39'd1 << 32) ^ (39'd1 << 7) ^ 39'd1,
                 32'hDEADBEE7, 3'b001);

        // Back-to-back stream with random data and 0..4 flips.
        for (int n = 0; n < C_SOAK + 2; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                soak_check($sformatf("soak_pipe_%0d", n - 2), pipe_out(), s_d[n-2], s_nf[n-2]);
            end
            if (n < C_SOAK) begin
                s_d[n]  = $urandom;
                s_nf[n] = $urandom_range(0, 4);
                drive_enc(s_d[n]);
                #1;
                cw   = u_bus.enc_c;
                mask = '0;
                k    = 0;
                while (k < s_nf[n]) begin
                    pos = $urandom_range(0, 38);
                    if (!mask[pos]) begin
                        mask[pos] = 1'b1;
                        k++;
                    end
                end
                drive_dec(cw ^ mask);
                #1;
                soak_check($sformatf("soak_comb_%0d", n), comb_out(), s_d[n], s_nf[n]);
            end
        end

        // Mid-stream reset: outputs clear at once, then the pipeline refills.
        @(negedge clk);
        drive_dec(C_CW_BEEF ^ (39'd1 << 20));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_async", 64'(pipe_out()), 64'(0));
        drive_dec(C_CW_BEEF);
        @(posedge clk);
        #1;
        check_eq("midrst_held", 64'(pipe_out()), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_edge1", 64'(pipe_out()), 64'({32'h0, 3'b100}));
        @(posedge clk);
        #1;
        check_eq("midrst_edge2", 64'(pipe_out()), 64'({C_BEEF, 3'b100}));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
